dbus_uncache_router: RTL and testbench
======================================

Name: dbus_uncache_router

Overview:
- Sits directly downstream of the address-translation stage on the data side.
- Consumes the translated data request and its uncached flag, and steers each transaction to one of two targets: the data cache path or the uncached bus path.
- Holds that routing decision until the transaction completes and muxes the response back to the CPU.
- Allows at most one outstanding transaction. Provides a sticky watchdog flag and an uncached-access counter.

Parameters:
- TIMEOUT, 1024: cycles a transaction may stay in ADDR/DATA before bus_timeout sets; 0 disables the watchdog.
- CNT_W, 32: width of the completed-uncached-transaction counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- dreq  input  dbus_req_t  translated request from the translation stage (valid, addr, size, strobe, data)
- uncached  input  1  uncached flag for dreq, same cycle
- dresp  output  dbus_resp_t  response to CPU (addr_ok, data_ok, data)
- dcreq  output  dbus_req_t  request to data cache
- dcresp  input  dbus_resp_t  response from data cache
- ucreq  output  dbus_req_t  request to uncached bus path
- ucresp  input  dbus_resp_t  response from uncached path
- bus_timeout  output  1  sticky watchdog error
- uc_count  output  CNT_W  completed uncached transactions, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - State IDLE, sel_q=0, wd_cnt=0, bus_timeout=0, uc_count=0.
  - While reset is high: dcreq.valid=0, ucreq.valid=0, dresp all-zero.
- Selection signal: sel = uncached in IDLE; sel = sel_q in ADDR and DATA.
- Request forwarding (combinational):
  - dreq payload goes to both targets.
  - Only the selected target sees valid; the other target sees valid=0.
- Response path: dresp = selected target's response. The unselected target's addr_ok/data_ok are ignored.
- CPU protocol: the CPU holds dreq stable until addr_ok; data_ok arrives in the same cycle or later.
- FSM: IDLE, ADDR, DATA.
  - IDLE, dreq.valid=0: stay.
  - IDLE, dreq.valid=1: forward with 0-cycle latency; capture sel_q<=uncached.
    - addr_ok & data_ok -> IDLE
    - addr_ok only -> DATA
    - neither -> ADDR
  - ADDR: forward dreq.valid to target sel_q.
    - addr_ok & data_ok -> IDLE
    - addr_ok -> DATA
    - else stay
  - DATA: forwarded valid forced to 0; dresp.addr_ok forced to 0, so no new request is accepted. On data_ok -> IDLE.
- Back-to-back: after completion, the next request is accepted in the following cycle (IDLE). There is no same-cycle pipelining of a second request.
- uncached changing mid-transaction (ADDR/DATA) is ignored; routing follows sel_q.
- uc_count increments by 1 on the cycle data_ok is delivered for a transaction with selection=1.
- Watchdog:
  - wd_cnt clears on entering IDLE and increments each cycle in ADDR/DATA.
  - When wd_cnt==TIMEOUT-1 and the transaction has not completed, bus_timeout<=1.
  - bus_timeout is sticky until reset. The FSM keeps waiting; no abort.
  - Saturate wd_cnt once bus_timeout is set.
- Reset mid-transaction: immediately returns to IDLE. Targets see valid drop asynchronously; the in-flight response is discarded.
- A data_ok from the unselected target (protocol violation) is ignored and does not change state.

Decomposition:
- Shared package (existing def.svh types): dbus_req_t, dbus_resp_t.
- Add to the package: router_state_t enum {IDLE, ADDR, DATA}.
- Sub-module dbus_watchdog: counter plus sticky flag, with params TIMEOUT and a 1-bit busy input. The rest is a flat FSM.

Test Plan:
- Cached single-cycle read:
  - Stimulus: dreq.valid=1, addr=0x0000_1000, uncached=0; dcresp addr_ok=data_ok=1, data=0xDEADBEEF in the same cycle.
  - Response: dresp.data_ok=1, data=0xDEADBEEF at 0 latency; ucreq.valid=0 throughout; uc_count=0.
- Uncached split transaction:
  - Stimulus: uncached=1, addr=0x1FC0_0000; ucresp addr_ok in cycle 2, data_ok in cycle 5.
  - Response: dresp.addr_ok in cycle 2, data_ok in cycle 5; dresp.addr_ok=0 in cycles 3-4; uc_count=1.
- Flag flip mid-flight:
  - Stimulus: uncached goes 1 -> 0 while in ADDR.
  - Response: ucreq stays valid; dcreq.valid stays 0 until completion.
- Spurious response:
  - Stimulus: dcresp.data_ok pulses while sel_q=1 in DATA.
  - Response: dresp.data_ok=0; state stays DATA.
- Watchdog:
  - Stimulus: TIMEOUT=8; target never asserts addr_ok.
  - Response: bus_timeout rises 8 cycles after acceptance and remains 1.
- Reset mid-transaction:
  - Stimulus: assert reset asynchronously during DATA.
  - Response: dcreq/ucreq valid=0 and dresp=0 immediately; after release, a new cached request completes normally with uc_count=0 and bus_timeout=0.

Source files
------------

// File: rtl/dbus_uncache_router_pkg.sv
// -----------------------------------------------------------------------------
// dbus_uncache_router_pkg
// Shared data-bus request/response types and the router state encoding.
//   dbus_req_t     : CPU-side request (valid, addr, size, strobe, data)
//   dbus_resp_t    : target response (addr_ok, data_ok, data)
//   router_state_t : IDLE / ADDR / DATA transaction phases
// -----------------------------------------------------------------------------
package dbus_uncache_router_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } router_state_t;

endpackage

// File: rtl/dbus_watchdog.sv
// -----------------------------------------------------------------------------
// dbus_watchdog
// Counts cycles a transaction stays outstanding and raises a sticky error flag
// once it has been outstanding for TIMEOUT cycles. TIMEOUT=0 disables the flag.
//   i_clk     : clock
//   i_rst     : asynchronous active-high reset
//   i_busy    : transaction outstanding and not completing this cycle
//   o_timeout : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module dbus_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  output logic o_timeout
);

  localparam int         W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam bit         EN   = (TIMEOUT != 0);

  logic [W-1:0] r_cnt;
  logic         r_timeout;

  // Cycle counter and sticky flag; the counter freezes once the flag is set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (!i_busy) begin
      r_cnt     <= '0;
    end else if (!r_timeout) begin
      if (EN && (r_cnt == LAST)) begin
        r_timeout <= 1'b1;
      end else begin
        r_cnt     <= r_cnt + W'(1);
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/dbus_uncache_router.sv
// -----------------------------------------------------------------------------
// dbus_uncache_router
// Steers each translated data request to the data cache or the uncached bus
// path, holds that choice until the transaction completes, and muxes the
// selected target's response back to the CPU. One transaction outstanding.
//   clk, reset  : clock, asynchronous active-high reset
//   dreq        : translated request from the CPU side
//   uncached    : routing flag for dreq (sampled only in IDLE)
//   dresp       : response to the CPU
//   dcreq/dcresp: data cache request/response
//   ucreq/ucresp: uncached path request/response
//   bus_timeout : sticky watchdog error
//   uc_count    : completed uncached transactions (wraps)
// -----------------------------------------------------------------------------
module dbus_uncache_router
  import dbus_uncache_router_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        dreq,
  input  logic             uncached,
  output dbus_resp_t       dresp,
  output dbus_req_t        dcreq,
  input  dbus_resp_t       dcresp,
  output dbus_req_t        ucreq,
  input  dbus_resp_t       ucresp,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] uc_count
);

  router_state_t    r_state;
  router_state_t    w_state_nxt;
  logic             r_sel;
  logic             w_sel;
  logic             w_fwd_valid;
  logic             w_addr_hs;
  logic             w_data_hs;
  logic             w_busy;
  dbus_resp_t       w_resp;
  logic [CNT_W-1:0] r_uc_count;

  // Routing selection, response mux and handshake qualification.
  always_comb begin
    w_sel       = r_sel;
    w_fwd_valid = 1'b0;
    w_addr_hs   = 1'b0;
    w_data_hs   = 1'b0;
    w_resp      = dcresp;
    if (r_state == IDLE) begin
      w_sel = uncached;
    end else begin
      w_sel = r_sel;
    end
    if (w_sel) begin
      w_resp = ucresp;
    end else begin
      w_resp = dcresp;
    end
    // In DATA the request was already taken; nothing new is forwarded.
    w_fwd_valid = dreq.valid & (r_state != DATA);
    w_addr_hs   = w_fwd_valid & w_resp.addr_ok;
    // Outside DATA a data_ok only counts together with the address handshake.
    if (r_state == DATA) begin
      w_data_hs = w_resp.data_ok;
    end else begin
      w_data_hs = w_addr_hs & w_resp.data_ok;
    end
    w_busy = (r_state != IDLE) & ~w_data_hs;
  end

  // Request fan-out and CPU response; everything is quiet while in reset.
  always_comb begin
    dcreq = dreq;
    ucreq = dreq;
    dresp = '0;
    if (reset) begin
      dcreq.valid = 1'b0;
      ucreq.valid = 1'b0;
      dresp       = '0;
    end else begin
      dcreq.valid   = w_fwd_valid & ~w_sel;
      ucreq.valid   = w_fwd_valid & w_sel;
      dresp.addr_ok = w_addr_hs;
      dresp.data_ok = w_data_hs;
      dresp.data    = w_resp.data;
    end
  end

  // Next-state logic for the single-outstanding transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ADDR: begin
        if (w_data_hs) begin
          w_state_nxt = IDLE;
        end else if (w_addr_hs) begin
          w_state_nxt = DATA;
        end else if (w_fwd_valid) begin
          w_state_nxt = ADDR;
        end else begin
          w_state_nxt = r_state;
        end
      end
      DATA: begin
        if (w_data_hs) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DATA;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured routing choice and uncached completion counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_uc_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && dreq.valid) begin
        r_sel <= uncached;
      end
      if (w_data_hs && w_sel) begin
        r_uc_count <= r_uc_count + CNT_W'(1);
      end
    end
  end

  assign uc_count = r_uc_count;

  dbus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_busy    (w_busy),
    .o_timeout (bus_timeout)
  );

endmodule

// File: tb/tb_dbus_uncache_router.sv
module tb_dbus_uncache_router;
  import dbus_uncache_router_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   dreq;
  logic        uncached;
  dbus_resp_t  dresp;
  dbus_req_t   dcreq;
  dbus_resp_t  dcresp;
  dbus_req_t   ucreq;
  dbus_resp_t  ucresp;
  logic        bus_timeout;
  logic [31:0] uc_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_uc   = 32'd0;
  logic        exp_to   = 1'b0;

  always #5 clk = ~clk;

  dbus_uncache_router #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .uncached(uncached),
    .dresp(dresp), .dcreq(dcreq), .dcresp(dcresp),
    .ucreq(ucreq), .ucresp(ucresp),
    .bus_timeout(bus_timeout), .uc_count(uc_count)
  );

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1, "time limit");
  end

  // Idle CPU, both targets emit random noise.
  task automatic drive_idle();
    dreq.valid  = 1'b0;
    dreq.addr   = $urandom;
    dreq.size   = 3'd2;
    dreq.strobe = 4'hF;
    dreq.data   = $urandom;
    uncached    = 1'($urandom_range(0, 1));
    dcresp      = '{addr_ok: 1'($urandom_range(0, 1)), data_ok: 1'($urandom_range(0, 1)), data: $urandom};
    ucresp      = '{addr_ok: 1'($urandom_range(0, 1)), data_ok: 1'($urandom_range(0, 1)), data: $urandom};
  endtask

  // One transaction: accepted in cycle 0, target addr_ok in cycle a,
  // data_ok in cycle d (d >= a). flip_mode: 0 hold flag, 1 invert after
  // cycle 0, 2 random after cycle 0. other_mode: 0 quiet, 1 random, 2 always ok.
  task automatic run_txn(input logic unc, input logic [31:0] addr, input int a, input int d,
                         input logic [31:0] val, input int flip_mode, input int other_mode);
    dbus_resp_t  sel_r;
    dbus_resp_t  oth_r;
    logic [31:0] wdata;
    logic        e_uv;
    logic        e_dv;
    wdata = $urandom;
    for (int c = 0; c <= d; c++) begin
      @(posedge clk); #1;
      dreq.valid  = (c <= a);
      dreq.addr   = addr;
      dreq.size   = 3'd2;
      dreq.strobe = 4'hF;
      dreq.data   = wdata;
      uncached    = unc;
      if (c > 0 && flip_mode == 1) uncached = ~unc;
      if (c > 0 && flip_mode == 2) uncached = 1'($urandom_range(0, 1));
      sel_r.addr_ok = (c == a);
      sel_r.data_ok = (c == d);
      sel_r.data    = (c == d) ? val : $urandom;
      oth_r.data    = $urandom;
      if (other_mode == 1) begin
        oth_r.addr_ok = 1'($urandom_range(0, 1));
        oth_r.data_ok = 1'($urandom_range(0, 1));
      end else begin
        oth_r.addr_ok = (other_mode == 2);
        oth_r.data_ok = (other_mode == 2);
      end
      if (unc) begin
        ucresp = sel_r; dcresp = oth_r;
      end else begin
        dcresp = sel_r; ucresp = oth_r;
      end
      @(negedge clk);
      e_uv = unc && (c <= a);
      e_dv = !unc && (c <= a);
      n_checks++;
      if (ucreq.valid !== e_uv) $display("FAIL ucreq_valid cyc=%0d got=%b exp=%b", c, ucreq.valid, e_uv);
      else n_pass++;
      n_checks++;
      if (dcreq.valid !== e_dv) $display("FAIL dcreq_valid cyc=%0d got=%b exp=%b", c, dcreq.valid, e_dv);
      else n_pass++;
      if (c <= a) begin
        n_checks++;
        if (dcreq.addr !== addr || ucreq.addr !== addr || ucreq.data !== wdata)
          $display("FAIL payload cyc=%0d got=%h/%h exp=%h", c, dcreq.addr, ucreq.addr, addr);
        else n_pass++;
      end
      n_checks++;
      if (dresp.addr_ok !== (c == a)) $display("FAIL addr_ok cyc=%0d got=%b exp=%b", c, dresp.addr_ok, (c == a));
      else n_pass++;
      n_checks++;
      if (dresp.data_ok !== (c == d)) $display("FAIL data_ok cyc=%0d got=%b exp=%b", c, dresp.data_ok, (c == d));
      else n_pass++;
      if (c == d) begin
        n_checks++;
        if (dresp.data !== val) $display("FAIL rdata cyc=%0d got=%h exp=%h", c, dresp.data, val);
        else n_pass++;
      end
      n_checks++;
      if (uc_count !== exp_uc || bus_timeout !== exp_to)
        $display("FAIL status cyc=%0d got=%0d/%b exp=%0d/%b", c, uc_count, bus_timeout, exp_uc, exp_to);
      else n_pass++;
      if (c == d && unc) exp_uc = exp_uc + 32'd1;
    end
  endtask

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      n_checks++;
      if (dresp.addr_ok !== 1'b0 || dresp.data_ok !== 1'b0 || dcreq.valid !== 1'b0 || ucreq.valid !== 1'b0)
        $display("FAIL idle_quiet got=%b%b%b%b exp=0000", dresp.addr_ok, dresp.data_ok, dcreq.valid, ucreq.valid);
      else n_pass++;
      n_checks++;
      if (uc_count !== exp_uc || bus_timeout !== exp_to)
        $display("FAIL idle_status got=%0d/%b exp=%0d/%b", uc_count, bus_timeout, exp_uc, exp_to);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    dreq.valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dcreq.valid !== 1'b0 || ucreq.valid !== 1'b0 || dresp !== '0)
      $display("FAIL reset_outputs got=%b/%b/%h exp=0/0/0", dcreq.valid, ucreq.valid, dresp);
    else n_pass++;
    n_checks++;
    if (uc_count !== 32'd0 || bus_timeout !== 1'b0)
      $display("FAIL reset_status got=%0d/%b exp=0/0", uc_count, bus_timeout);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();
  endtask

  task automatic test_cached_single();
    run_txn(1'b0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 0, 1);
    test_idle(1);
  endtask

  task automatic test_uncached_split();
    run_txn(1'b1, 32'h1FC0_0000, 2, 5, 32'h0BAD_F00D, 0, 1);
    test_idle(1);
  endtask

  task automatic test_flag_flip();
    run_txn(1'b1, 32'h1FC0_0040, 3, 5, 32'h1357_9BDF, 1, 0);
  endtask

  task automatic test_spurious();
    run_txn(1'b1, 32'h1FC0_0080, 1, 4, 32'h2468_ACE0, 0, 2);
    run_txn(1'b0, 32'h0000_3000, 1, 3, 32'h8765_4321, 0, 2);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 32'h1FC0_0100, 0, 0, 32'h1111_1111, 0, 1);
    run_txn(1'b0, 32'h0000_0100, 0, 0, 32'h2222_2222, 0, 1);
    run_txn(1'b1, 32'h1FC0_0104, 0, 1, 32'h3333_3333, 0, 1);
    run_txn(1'b1, 32'h1FC0_0108, 1, 1, 32'h4444_4444, 0, 1);
  endtask

  task automatic test_random();
    int a;
    int d;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 4);
      d = a + $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), $urandom, a, d, $urandom, 2, 1);
      test_idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_watchdog();
    int  busy_done;
    logic e_to;
    for (int k = 0; k <= 15; k++) begin
      @(posedge clk); #1;
      dreq.valid  = 1'b1;
      dreq.addr   = 32'h0000_2000;
      dreq.size   = 3'd2;
      dreq.strobe = 4'hF;
      dreq.data   = 32'h0;
      uncached    = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      dcresp      = '{addr_ok: (k == 15), data_ok: (k == 15), data: 32'h5A5A_0F0F};
      ucresp      = '{addr_ok: 1'($urandom_range(0, 1)), data_ok: 1'($urandom_range(0, 1)), data: $urandom};
      @(negedge clk);
      busy_done = (k > 0) ? k - 1 : 0;
      e_to = (busy_done >= TO);
      n_checks++;
      if (bus_timeout !== e_to) $display("FAIL wd_flag k=%0d got=%b exp=%b", k, bus_timeout, e_to);
      else n_pass++;
      n_checks++;
      if (dresp.addr_ok !== (k == 15) || dresp.data_ok !== (k == 15) || dcreq.valid !== 1'b1)
        $display("FAIL wd_hold k=%0d got=%b%b%b exp=%b%b1", k, dresp.addr_ok, dresp.data_ok, dcreq.valid, (k == 15), (k == 15));
      else n_pass++;
    end
    exp_to = 1'b1;
    test_idle(3);
    run_txn(1'b0, 32'h0000_2004, 0, 1, 32'h7777_0000, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 32'h1FC0_0200; uncached = 1'b1;
    ucresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    dcresp = '0;
    @(negedge clk);
    n_checks++;
    if (dresp.addr_ok !== 1'b1) $display("FAIL rm_accept got=%b exp=1", dresp.addr_ok);
    else n_pass++;
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    ucresp = '0;
    @(negedge clk);
    n_checks++;
    if (dresp.data_ok !== 1'b0 || dresp.addr_ok !== 1'b0) $display("FAIL rm_data_wait got=%b%b exp=00", dresp.addr_ok, dresp.data_ok);
    else n_pass++;
    #2;
    reset = 1'b1;
    dreq.valid = 1'b1;
    ucresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFE_BABE};
    dcresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFE_BABE};
    #1;
    n_checks++;
    if (dcreq.valid !== 1'b0 || ucreq.valid !== 1'b0 || dresp !== '0)
      $display("FAIL rm_outputs got=%b/%b/%h exp=0/0/0", dcreq.valid, ucreq.valid, dresp);
    else n_pass++;
    n_checks++;
    if (bus_timeout !== 1'b0 || uc_count !== 32'd0)
      $display("FAIL rm_status got=%b/%0d exp=0/0", bus_timeout, uc_count);
    else n_pass++;
    exp_uc = 32'd0;
    exp_to = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();
    run_txn(1'b0, 32'h0000_1000, 0, 1, 32'h1234_5678, 0, 0);
    test_idle(2);
  endtask

  initial begin
    test_reset();
    test_cached_single();
    test_uncached_split();
    test_flag_flip();
    test_spurious();
    test_back_to_back();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
